instruction_fetch: RTL and testbench

//  Fetch stage directly downstream of the PC: owns the fetch PC and issues in-order word requests to instruction memory.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/instruction_fetch.sv | 82 ++++++++
 tb/tb_instruction_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared width, reset PC default and queue entry layout for the fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two synchronous FIFO with flush and occupancy count
module fetch_queue #(
    parameter int W = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop && count_q != '0;
    assign do_push = push && (count_q != CW'(DEPTH) || do_pop);
    assign head    = mem_q[rd_q];
    assign count   = count_q;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d    = flush ? '0 : wr_q + AW'(do_push);
        rd_d    = flush ? '0 : rd_q + AW'(do_pop);
        count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the fetch PC, issues credit-limited word requests and queues
// returned instructions for decode, squashing wrong-path responses on redirect
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_fault,
    input  logic            id_ready
);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d, occupancy, outstanding, in_flight;
    logic [CW:0]     credit_used;
    logic            halted_q, halted_d, fault_pend_q, fault_pend_d;
    logic            req_fire, deq, rsp_keep, fault_push, misaligned;
    fetch_entry_t    q_in, q_head;

    fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_data_q (
        .clk(clk), .rst_n(rst_n), .flush(redirect_valid), .push(rsp_keep || fault_push),
        .push_data(q_in), .pop(deq), .head(q_head), .count(occupancy)
    );

    // PC tag per request in flight; its count doubles as the outstanding counter
    fetch_queue #(.W(XLEN), .DEPTH(QDEPTH)) u_tag_q (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .push(req_fire),
        .push_data(fetch_pc_q), .pop(imem_rsp_valid), .head(tag_pc), .count(outstanding)
    );

    assign if_valid      = occupancy != '0;
    assign if_instr      = q_head.instr;
    assign if_pc         = q_head.pc;
    assign if_fault      = q_head.fault;
    assign imem_req_addr = fetch_pc_q;
    assign deq           = if_valid && id_ready && !redirect_valid;
    assign misaligned    = redirect_pc[1:0] != 2'b00;
    // the slot freed by this cycle's dequeue is already counted as available
    assign credit_used   = (CW+1)'(occupancy) - (CW+1)'(deq) + (CW+1)'(outstanding);
    assign imem_req_valid = rst_n && !halted_q && !redirect_valid && credit_used < (CW+1)'(QDEPTH);
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign in_flight     = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign rsp_keep      = imem_rsp_valid && drop_cnt_q == '0 && !redirect_valid;
    assign fault_push    = fault_pend_q && drop_cnt_q == '0 && !redirect_valid;

    always_comb begin
        q_in = fault_push ? {XLEN'(0), fetch_pc_q, 1'b1} : {imem_rsp_data, tag_pc, imem_rsp_err};
        fetch_pc_d = redirect_valid ? redirect_pc : req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        drop_cnt_d = (redirect_valid || (rsp_keep && imem_rsp_err)) ? in_flight :
                     (imem_rsp_valid && drop_cnt_q != '0) ? drop_cnt_q - CW'(1) : drop_cnt_q;
        halted_d = redirect_valid ? misaligned : (rsp_keep && imem_rsp_err) ? 1'b1 : halted_q;
        fault_pend_d = redirect_valid ? misaligned : fault_push ? 1'b0 : fault_pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            drop_cnt_q   <= '0;
            halted_q     <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            drop_cnt_q   <= drop_cnt_d;
            halted_q     <= halted_d;
            fault_pend_q <= fault_pend_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed table, corner sequences and a random stream scoreboard
module tb_instruction_fetch;
    localparam int QD = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0, imem_rsp_err = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid, if_fault, id_ready = 1'b0;
    logic [31:0] if_instr, if_pc;

    instruction_fetch #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; logic err; } mreq_t;
    typedef struct { logic idr; logic exp_rv; logic [31:0] exp_addr; logic exp_ifv; logic [31:0] exp_pc; } vec_t;

    mreq_t       mq[$];
    vec_t        tv[$];
    logic [31:0] pop_pc[$], pop_instr[$], fire_addr[$];
    logic        pop_fault[$];
    int          checks = 0, failures = 0, cyc = 0, lat_lo = 1, lat_hi = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          rnd_err = 0;
    logic        s_rv, s_fire, s_ifv, s_pop, s_fault;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return (a == err_addr) || (rnd_err && a[7:0] == 8'hBC);
    endfunction

    function automatic vec_t mk(input logic idr, input logic rv, input logic [31:0] a, input logic ifv, input logic [31:0] pc);
        vec_t v;
        v.idr = idr; v.exp_rv = rv; v.exp_addr = a; v.exp_ifv = ifv; v.exp_pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_lists();
        pop_pc.delete(); pop_instr.delete(); pop_fault.delete(); fire_addr.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = '0;
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1; cyc = 0;
        clear_lists();
    endtask

    // one cycle: drive inputs at negedge, sample settled outputs, let the memory model see the edge
    task automatic step(input logic rv, input logic [31:0] rpc, input logic idr, input logic rdy);
        @(negedge clk);
        redirect_valid = rv; redirect_pc = rpc; id_ready = idr; imem_req_ready = rdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = mem_data(mq[0].addr); imem_rsp_err = mq[0].err;
        end else begin
            imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
        end
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_fire = imem_req_valid && rdy;
        s_ifv = if_valid; s_pc = if_pc; s_instr = if_instr; s_fault = if_fault;
        s_pop = if_valid && idr && !rv;
        if (s_pop) begin pop_pc.push_back(s_pc); pop_instr.push_back(s_instr); pop_fault.push_back(s_fault); end
        if (s_fire) fire_addr.push_back(s_addr);
        @(posedge clk);
        if (imem_rsp_valid) void'(mq.pop_front());
        if (s_fire) mq.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_lo, lat_hi)), err: is_err(s_addr)});
        cyc++;
    endtask

    initial begin
        logic [31:0] m_exp, m_req;
        bit m_dead, m_mis, m_mis_pend;
        int n_pop;
        #12;
        chk("reset req_valid", imem_req_valid, 0);
        chk("reset if_valid", if_valid, 0);
        chk("reset if_pc", if_pc, 0);
        chk("reset if_instr", if_instr, 0);
        chk("reset if_fault", if_fault, 0);

        // streaming at 1-cycle memory latency, then a 10-cycle decode stall
        tv.push_back(mk(1, 1, 32'h00, 0, 0));
        tv.push_back(mk(1, 1, 32'h04, 0, 0));
        tv.push_back(mk(1, 1, 32'h08, 1, 32'h00));
        tv.push_back(mk(1, 1, 32'h0C, 1, 32'h04));
        tv.push_back(mk(1, 1, 32'h10, 1, 32'h08));
        for (int i = 0; i < 10; i++) tv.push_back(mk(0, 0, 0, 1, 32'h0C));
        tv.push_back(mk(1, 1, 32'h14, 1, 32'h0C));
        tv.push_back(mk(1, 1, 32'h18, 1, 32'h10));
        tv.push_back(mk(1, 1, 32'h1C, 1, 32'h14));
        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            step(0, 0, tv[i].idr, 1);
            chk($sformatf("tbl%0d req_valid", i), s_rv, tv[i].exp_rv);
            if (tv[i].exp_rv) chk($sformatf("tbl%0d req_addr", i), s_addr, tv[i].exp_addr);
            chk($sformatf("tbl%0d if_valid", i), s_ifv, tv[i].exp_ifv);
            if (tv[i].exp_ifv) begin
                chk($sformatf("tbl%0d if_pc", i), s_pc, tv[i].exp_pc);
                chk($sformatf("tbl%0d if_instr", i), s_instr, mem_data(tv[i].exp_pc));
            end
        end

        // redirect with two requests in flight
        do_reset(); lat_lo = 3; lat_hi = 3;
        step(0, 0, 1, 1); step(0, 0, 1, 1);
        chk("A outstanding", fire_addr.size(), 2);
        step(1, 32'h100, 1, 1);
        chk("A redirect req_valid", s_rv, 0);
        step(0, 0, 1, 1);
        chk("A flushed if_valid", s_ifv, 0);
        for (int i = 0; i < 20 && pop_pc.size() == 0; i++) step(0, 0, 1, 1);
        chk("A first pc", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h100);
        chk("A first instr", pop_instr.size() > 0 ? pop_instr[0] : 32'hDEAD_BEEF, mem_data(32'h100));

        // full queue flushed by redirect
        do_reset(); lat_lo = 1; lat_hi = 1;
        repeat (5) step(0, 0, 0, 1);
        chk("B full if_valid", s_ifv, 1);
        chk("B full req_valid", s_rv, 0);
        step(1, 32'h200, 1, 1);
        step(0, 0, 1, 1);
        chk("B flushed if_valid", s_ifv, 0);
        chk("B resume req_valid", s_rv, 1);
        chk("B resume addr", s_addr, 32'h200);
        clear_lists();
        for (int i = 0; i < 10 && pop_pc.size() == 0; i++) step(0, 0, 1, 1);
        chk("B first pc", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h200);

        // bus error at 0x8 halts fetching until a redirect
        do_reset(); err_addr = 32'h8;
        repeat (12) step(0, 0, 1, 1);
        chk("C fires", fire_addr.size(), 4);
        chk("C pops", pop_pc.size(), 3);
        if (pop_pc.size() == 3) begin
            chk("C pc0", pop_pc[0], 32'h0); chk("C pc1", pop_pc[1], 32'h4); chk("C pc2", pop_pc[2], 32'h8);
            chk("C fault1", pop_fault[1], 0); chk("C fault2", pop_fault[2], 1);
        end
        chk("C halted req_valid", s_rv, 0);
        err_addr = 32'hFFFF_FFFF; clear_lists();
        step(1, 32'h40, 1, 1);
        repeat (8) step(0, 0, 1, 1);
        chk("C resume fire", fire_addr.size() > 0 ? fire_addr[0] : 32'hDEAD_BEEF, 32'h40);
        chk("C resume pc0", pop_pc.size() > 1 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h40);
        chk("C resume pc1", pop_pc.size() > 1 ? pop_pc[1] : 32'hDEAD_BEEF, 32'h44);
        chk("C resume fault", pop_fault.size() > 0 ? pop_fault[0] : 1'b1, 0);

        // misaligned redirect with one stale response in flight
        do_reset();
        step(0, 0, 1, 1);
        step(1, 32'h102, 1, 1);
        chk("D redirect req_valid", s_rv, 0);
        repeat (10) step(0, 0, 1, 1);
        chk("D fires", fire_addr.size(), 1);
        chk("D pops", pop_pc.size(), 1);
        if (pop_pc.size() == 1) begin
            chk("D pc", pop_pc[0], 32'h102); chk("D instr", pop_instr[0], 0); chk("D fault", pop_fault[0], 1);
        end

        // random stalls, latencies, redirects and bus errors against a stream model
        do_reset(); lat_lo = 1; lat_hi = 4; rnd_err = 1;
        m_exp = 0; m_req = 0; m_dead = 0; m_mis = 0; m_mis_pend = 0; n_pop = 0;
        for (int n = 0; n < 3000; n++) begin
            logic rv;
            logic [31:0] rpc;
            rv = $urandom_range(0, 19) == 0;
            rpc = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(rv, rpc, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
            if (s_fire) begin
                chk("rnd req_addr", s_addr, m_req);
                m_req = m_req + 4;
            end
            if (m_mis) chk("rnd fire while misaligned", s_fire, 0);
            if (s_pop) begin
                n_pop++;
                if (m_mis_pend) begin
                    chk("rnd mis pc", s_pc, m_exp); chk("rnd mis instr", s_instr, 0); chk("rnd mis fault", s_fault, 1);
                    m_mis_pend = 0; m_dead = 1;
                end else if (m_dead) begin
                    chk("rnd unexpected entry", s_pop, 0);
                end else begin
                    chk("rnd pc", s_pc, m_exp);
                    chk("rnd instr", s_instr, mem_data(m_exp));
                    chk("rnd fault", s_fault, is_err(m_exp));
                    if (is_err(m_exp)) m_dead = 1;
                    m_exp = m_exp + 4;
                end
            end
            if (rv) begin
                m_exp = rpc; m_req = rpc; m_dead = 0;
                m_mis = rpc[1:0] != 2'b00; m_mis_pend = m_mis;
            end
        end
        chk("rnd progress", n_pop > 200, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
